// File: rtl/alu_pkg.sv
// Opcode and FSM types shared by alu_pipe and its multiplier.
// Shift-amount width helper is used for both the shifter and the step counter.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_XOR  = 4'd4,
    OP_SRL  = 4'd5,
    OP_OR   = 4'd6,
    OP_AND  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  function automatic int shamt_w(input int data_size);
    return $clog2(data_size);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DataSize steps.
// done pulses combinationally on the final step with product valid alongside it.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int DataSize = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DataSize-1:0] a,
  input  logic [DataSize-1:0] b,
  output logic                done,
  output logic [DataSize-1:0] product
);

  localparam int CntW = shamt_w(DataSize);

  logic                active;
  logic [CntW-1:0]     cnt;
  logic [DataSize-1:0] acc;
  logic [DataSize-1:0] mcand;
  logic [DataSize-1:0] mplier;
  logic [DataSize-1:0] acc_nxt;

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign done    = active && (cnt == CntW'(DataSize - 1));
  // The last step's sum is the product, so it is presented before acc updates.
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (active) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; optional iterative MUL when
// ALU_PIPE_MUL_EN is defined (otherwise opcode 10 behaves as undefined).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DataSize  = 32,
  parameter int ALUopSize = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataSize-1:0]  src1,
  input  logic [DataSize-1:0]  src2,
  input  logic [ALUopSize-1:0] alu_type,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataSize-1:0]  alu_result,
  output logic                 zero,
  output logic                 busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; a producer holds its payload stable until that edge.

  localparam int ShW = shamt_w(DataSize);

  alu_state_e          state;
  alu_state_e          state_nxt;
  logic [31:0]         op_ext;
  alu_op_e             op;
  logic                op_in_range;
  logic [ShW-1:0]      shamt;
  logic                eq;
  logic                def_c;
  logic [DataSize-1:0] res_c;
  logic                zero_c;
  logic                accept;
  logic                mul_req;
  logic                mul_start;
  logic                mul_done;
  logic                mul_eq;
  logic [DataSize-1:0] mul_product;

  assign op_ext      = 32'(alu_type);
  assign op          = alu_op_e'(op_ext[ALU_OP_W-1:0]);
  // Opcodes wider than the enum must have zero upper bits to be defined.
  assign op_in_range = (op_ext >> ALU_OP_W) == 32'd0;
  assign shamt       = src2[ShW-1:0];
  assign eq          = (src1 == src2);

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && mul_req;
  assign busy      = (state == MUL);

  always_comb begin
    res_c   = '0;
    def_c   = op_in_range;
    mul_req = 1'b0;
    case (op)
      OP_ADD:  res_c = src1 + src2;
      OP_SUB:  res_c = src1 - src2;
      OP_SLL:  res_c = src1 << shamt;
      OP_SLT:  res_c = DataSize'($signed(src1) < $signed(src2));
      OP_XOR:  res_c = src1 ^ src2;
      OP_SRL:  res_c = src1 >> shamt;
      OP_OR:   res_c = src1 | src2;
      OP_AND:  res_c = src1 & src2;
      OP_SRA:  res_c = $unsigned($signed(src1) >>> shamt);
      OP_SLTU: res_c = DataSize'(src1 < src2);
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  mul_req = op_in_range;
`endif
      default: def_c = 1'b0;
    endcase
    if (!op_in_range) begin
      res_c = '0;
    end
    zero_c = def_c && eq;
  end

`ifdef ALU_PIPE_MUL_EN
  alu_mul_iter #(
    .DataSize(DataSize)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (src1),
    .b       (src2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_eq <= 1'b0;
    end else if (mul_start) begin
      mul_eq <= eq;
    end
  end
`else
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign mul_eq      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MUL;
      MUL:     if (mul_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MUL completion can load unconditionally: the output was empty on entry
  // and nothing else is accepted until the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b0;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      alu_result <= mul_product;
      zero       <= mul_eq;
    end else if (accept && !mul_req) begin
      out_valid  <= 1'b1;
      alu_result <= res_c;
      zero       <= zero_c;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases, then randomized traffic
// with random backpressure checked against a behavioural model and queue.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int EW = W + 1;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic [3:0]    alu_type = '0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_result;
  logic          zero;
  logic          busy;

  logic          rand_ready = 1'b0;
  logic          ready_forced = 1'b1;
  logic          rnd_ready = 1'b1;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [EW-1:0] exp_q[$];

  assign out_ready = rand_ready ? rnd_ready : ready_forced;

  alu_pipe #(
    .DataSize (W),
    .ALUopSize(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .alu_type  (alu_type),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_result(alu_result),
    .zero      (zero),
    .busy      (busy)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int            sh;
    logic [W-1:0]  r;
    logic [2*W-1:0] p;
    logic          def;
    sh  = int'(b % W);
    r   = '0;
    def = 1'b1;
    p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a << sh;
      4'd3:  r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd4:  r = a ^ b;
      4'd5:  r = a >> sh;
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd8:  r = a[W-1] ? ~((~a) >> sh) : (a >> sh);
      4'd9:  r = {{(W-1){1'b0}}, (a < b)};
      4'd10: if (MulEn) r = p[W-1:0]; else def = 1'b0;
      default: def = 1'b0;
    endcase
    if (!def) return '0;
    return {(a == b), r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
    in_valid = 1'b1;
    alu_type = op;
    src1     = a;
    src2     = b;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout op=%0d waited=%0d cycles", op, k);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src1     = $urandom;
    src2     = $urandom;
    alu_type = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_mul(input string name, input logic [W-1:0] exp_res);
    int k;
    int busy_cnt;
    k        = 0;
    busy_cnt = 0;
    while (!out_valid && k < 60) begin
      if (busy) busy_cnt++;
      if (in_ready) check({name, "_in_ready"}, in_ready, 0);
      step(1);
      k++;
    end
    check({name, "_latency"}, k + 1, 33);
    check({name, "_busy_cycles"}, busy_cnt, 32);
    check({name, "_result"}, alu_result, exp_res);
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic [EW-1:0] e;
  logic [EW-1:0] prev_out;
  int            mul_wait = 0;
  bit            pend_single = 1'b0;
  bit            prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      mul_wait    = 0;
      pend_single = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_payload", {zero, alu_result}, prev_out);
      end
      if (pend_single) check("lat1_valid", out_valid, 1);
      if (mul_wait > 0) begin
        mul_wait--;
        if (mul_wait > 0) begin
          check("mul_busy", busy, 1);
          check("mul_in_ready", in_ready, 0);
          check("mul_no_valid", out_valid, 0);
        end else begin
          check("mul_done_valid", out_valid, 1);
          check("mul_done_busy", busy, 0);
        end
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h expected=none", {zero, alu_result});
        end else begin
          e = exp_q.pop_front();
          check("result", {zero, alu_result}, e);
        end
      end
      pend_single = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(alu_type, src1, src2));
        if (MulEn && alu_type == 4'd10) mul_wait = 33;
        else pend_single = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {zero, alu_result};
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    bit saw;
    logic [3:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Pin the model against hand-computed values.
    check("model_add_wrap", model(4'd0, 32'hFFFF_FFFF, 32'd1), 33'h0_0000_0000);
    check("model_sra", model(4'd8, 32'h8000_0000, 32'd35), 33'h0_F000_0000);
    check("model_srl", model(4'd5, 32'h8000_0000, 32'd35), 33'h0_1000_0000);
    check("model_sltu", model(4'd9, 32'hFFFF_FFFF, 32'd1), 33'h0_0000_0000);
    check("model_xor_eq", model(4'd4, 32'd6, 32'd6), 33'h1_0000_0000);
`ifdef ALU_PIPE_MUL_EN
    check("model_mul", model(4'd10, 32'd12345, 32'd6789), {1'b0, 32'd83810205});
`endif

    // Reset state.
    step(3);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", {zero, alu_result}, 0);
    check("reset_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    step(1);

    // ADD/SUB wrap, shifts, compares, undefined ops.
    send(4'd0, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap_valid", out_valid, 1);
    check("add_wrap", {zero, alu_result}, 33'h0_0000_0000);
    send(4'd1, 32'd5, 32'd7);
    check("sub_wrap", {zero, alu_result}, 33'h0_FFFF_FFFE);
    send(4'd8, 32'h8000_0000, 32'd35);
    check("sra_amt3", alu_result, 32'hF000_0000);
    send(4'd5, 32'h8000_0000, 32'd35);
    check("srl_amt3", alu_result, 32'h1000_0000);
    send(4'd3, 32'hFFFF_FFFF, 32'd1);
    check("slt_signed", alu_result, 32'd1);
    send(4'd9, 32'hFFFF_FFFF, 32'd1);
    check("sltu_unsigned", alu_result, 32'd0);
    send(4'd15, 32'd9, 32'd9);
    check("undef_op15", {out_valid, zero, alu_result}, {1'b1, 33'h0});
`ifndef ALU_PIPE_MUL_EN
    send(4'd10, 32'd7, 32'd7);
    check("mul_disabled", {out_valid, zero, alu_result, busy}, {1'b1, 33'h0, 1'b0});
`endif

    // Backpressure: ADD then XOR with out_ready low for 3 cycles.
    step(2);
    ready_forced = 1'b0;
    send(4'd0, 32'd2, 32'd3);
    in_valid = 1'b1;
    alu_type = 4'd4;
    src1     = 32'd6;
    src2     = 32'd6;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", alu_result, 32'd5);
      check("bp_in_ready", in_ready, 0);
      step(1);
    end
    ready_forced = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_xor", {out_valid, zero, alu_result}, {1'b1, 1'b1, 32'h0});

    // Throughput: 8 back-to-back single-cycle ops.
    step(1);
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(4'($urandom_range(0, 9)), $urandom, $urandom);
    end
    check("throughput_cycles", cyc - c0, 8);
    step(2);

`ifdef ALU_PIPE_MUL_EN
    send(4'd10, 32'd12345, 32'd6789);
    wait_mul("mul_a", 32'd83810205);
    step(1);
    send(4'd10, 32'hFFFF_FFFF, 32'd2);
    wait_mul("mul_b", 32'hFFFF_FFFE);
    step(1);
    // Reset in the middle of a multiply.
    send(4'd10, 32'd12345, 32'd6789);
    step(9);
`else
    ready_forced = 1'b0;
    send(4'd0, 32'd2, 32'd3);
    step(1);
`endif
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_result", {zero, alu_result}, 0);
    ready_forced = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("rst_no_stale_result", saw, 0);
    step(1);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send(op, a, b);
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
    end
    rand_ready   = 1'b0;
    ready_forced = 1'b1;
    step(50);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the execute-stage ALU.
- Accepts one operation per cycle over a valid/ready handshake and returns a registered result plus an equality flag.
- Adds arithmetic right shift, unsigned compare and an optional iterative multiplier.
- Output is backpressure-aware, so it can sit between a decode stage and a writeback stage that may stall.

Parameters:
- DataSize, 32, operand/result width; must be a power of two, >= 8.
- ALUopSize, 4, opcode width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation this cycle.
- src1  input  DataSize  operand 1.
- src2  input  DataSize  operand 2.
- alu_type  input  ALUopSize  opcode.
- out_valid  output  1  alu_result/zero are valid.
- out_ready  input  1  consumer accepts the result.
- alu_result  output  DataSize  registered result.
- zero  output  1  registered (src1 == src2) of the accepted operation.
- busy  output  1  multiplier iteration in progress.

Behaviour:
- Opcodes:
  - ADD=0, SUB=1, SLL=2, SLT=3, XOR=4, SRL=5, OR=6, AND=7, SRA=8, SLTU=9, MUL=10.
  - Any other opcode, or MUL when the feature is absent, yields alu_result=0 and zero=0, with latency 1.
- Arithmetic: all ops are modulo 2^DataSize.
  - Shift amount is src2[$clog2(DataSize)-1:0]; upper bits are ignored.
  - SLT compares signed and SLTU compares unsigned; both give 1 or 0, zero-extended.
  - SRA replicates src1[DataSize-1].
- Zero: zero = (src1 == src2) for every defined op, including MUL.
- Handshake:
  - An operation is accepted when in_valid && in_ready.
  - The result is consumed when out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready), so the block accepts a new op in the same cycle the old result drains.
- Latency:
  - Single-cycle ops: result is registered on the accepting edge, and out_valid=1 on the next cycle.
  - Full throughput of 1 op/cycle when out_ready is held high.
- Output hold: while out_valid && !out_ready, alu_result, zero and out_valid hold stable and in_ready=0.
- FSM states: IDLE, MUL.
  - IDLE -> MUL on accepting MUL (feature present). Operands are latched, product accumulator and counter are cleared, and busy=1.
  - In MUL, one shift-add step is done per cycle (LSB of multiplier selects adding the shifted multiplicand); counter counts 0..DataSize-1.
  - On the last step, the low DataSize bits are loaded into alu_result, out_valid=1, busy=0 and the FSM returns to IDLE. MUL latency is DataSize+1 cycles from acceptance to out_valid (33 at default).
  - The MUL completion edge loads the output register unconditionally; this is always safe because in_ready=0 during MUL and out_valid was already clear on entry.
  - in_ready=0 throughout MUL; in_valid is ignored.
- Reset (rst low, asynchronous, any state, including mid-MUL):
  - state=IDLE, out_valid=0, alu_result=0, zero=0, busy=0, counter=0, accumulator=0.
  - in_ready becomes 1 on the first cycle after rst deasserts.
  - An in-flight multiply is discarded with no output.
- Inputs are sampled only on acceptance; changing them at other times has no effect.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined: MUL opcode 10 performs the iterative multiply described above; busy is functional.
- Undefined: no accumulator, counter or MUL state is synthesised. Opcode 10 is treated as undefined (result 0, zero 0, latency 1). busy is tied to 0 and the FSM stays in IDLE.

Decomposition:
- Package alu_pkg:
  - typedef enum alu_op_e holding the 11 opcode constants, width ALUopSize.
  - typedef enum alu_state_e {IDLE, MUL}.
  - localparam function for shift-amount width.
- Sub-module alu_mul_iter (only under ALU_PIPE_MUL_EN):
  - start/operands in, done/product out, counter internal.
  - alu_pipe instantiates it and owns the handshake and output register.

Test Plan:
- ADD/SUB wrap: src1=32'hFFFF_FFFF, src2=1, ADD -> alu_result=0, zero=0, one cycle after accept. Then SUB 5-7 -> 32'hFFFF_FFFE.
- Shifts and compares, with src1=32'h8000_0000:
  - SRA by src2=35 (amount 3) -> 32'hF000_0000; SRL same -> 32'h1000_0000.
  - SLT(32'hFFFF_FFFF, 1) -> 1; SLTU same -> 0.
- Backpressure: issue ADD 2+3 then XOR 6^6 back-to-back with out_ready=0 for 3 cycles.
  - alu_result holds 5, out_valid holds 1 and in_ready=0.
  - Raising out_ready drains 5, and the next cycle presents 0 with zero=1.
- Throughput: 8 consecutive ops with in_valid and out_ready high -> one result per cycle, no bubbles, in order.
- MUL (macro defined): 32'd12345 * 32'd6789 -> 83810205 with out_valid exactly 33 cycles after accept, busy high for 32 cycles, in_ready=0 throughout. Also 32'hFFFF_FFFF*2 -> 32'hFFFF_FFFE.
- Reset mid-MUL / undefined op:
  - Drive rst low at cycle 10 of a MUL -> out_valid=0, busy=0, alu_result=0 immediately (asynchronously), and no result after release.
  - Opcode 15 (and 10 without the macro) -> alu_result=0, zero=0 after 1 cycle.
